// File: rtl/oai211_sweep_ctrl.sv
// Built-in self-test sequencer for a single OAI211 cell (ZN = ~((C1|C2)&A&B)).
// Walks all 16 input vectors in ascending order, holds each for SETTLE_CYCLES,
// samples ZN, and accumulates mismatch count plus the first failing vector.
module oai211_sweep_ctrl #(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    output logic       dut_a,
    output logic       dut_b,
    output logic       dut_c1,
    output logic       dut_c2,
    input  logic       dut_zn,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [4:0] err_count,
    output logic [3:0] first_fail_vec,
    output logic       first_fail_valid
);

    localparam int unsigned VEC_W = 4;
    localparam int unsigned CNT_W = 4;
    localparam int unsigned ERR_W = 5;

    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [VEC_W-1:0] VEC_LAST   = {VEC_W{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [VEC_W-1:0]   vec_q, vec_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ERR_W-1:0]   err_q, err_d;
    logic [VEC_W-1:0]   ffv_q, ffv_d;
    logic               ffvalid_q, ffvalid_d;
    logic               pass_q, pass_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [VEC_W-1:0]   drive_q, drive_d;

    logic               exp_c;
    logic               mismatch_c;

    // Golden OAI211 response for the vector currently applied.
    always_comb begin
        exp_c      = ~((vec_q[1] | vec_q[0]) & vec_q[3] & vec_q[2]);
        mismatch_c = (dut_zn != exp_c);
    end

    // Next-state and registered-output computation.
    always_comb begin
        state_d   = state_q;
        vec_d     = vec_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        ffv_d     = ffv_q;
        ffvalid_d = ffvalid_q;
        pass_d    = pass_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    vec_d     = '0;
                    err_d     = '0;
                    ffv_d     = '0;
                    ffvalid_d = 1'b0;
                    pass_d    = 1'b0;
                    cnt_d     = CNT_RELOAD;
                    state_d   = ST_SETTLE;
                end
            end

            ST_SETTLE: begin
                if (abort) begin
                    pass_d  = 1'b0;
                    state_d = ST_IDLE;
                end else if (cnt_q == '0) begin
                    state_d = ST_SAMPLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end

            ST_SAMPLE: begin
                if (abort) begin
                    // Compare in the abort cycle is intentionally dropped.
                    pass_d  = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    if (mismatch_c) begin
                        err_d = err_q + ERR_W'(1);
                        if (!ffvalid_q) begin
                            ffv_d     = vec_q;
                            ffvalid_d = 1'b1;
                        end
                    end
                    if (vec_q == VEC_LAST) begin
                        // Verdict uses the count including the final vector.
                        pass_d  = (err_d == '0);
                        state_d = ST_DONE;
                    end else begin
                        vec_d   = vec_q + VEC_W'(1);
                        cnt_d   = CNT_RELOAD;
                        state_d = ST_SETTLE;
                    end
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d  = (state_d == ST_SETTLE) || (state_d == ST_SAMPLE);
        done_d  = (state_d == ST_DONE);
        drive_d = busy_d ? vec_d : '0;
    end

    // State and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            vec_q     <= '0;
            cnt_q     <= '0;
            err_q     <= '0;
            ffv_q     <= '0;
            ffvalid_q <= 1'b0;
            pass_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            drive_q   <= '0;
        end else begin
            state_q   <= state_d;
            vec_q     <= vec_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
            ffv_q     <= ffv_d;
            ffvalid_q <= ffvalid_d;
            pass_q    <= pass_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            drive_q   <= drive_d;
        end
    end

    // Port mapping: {A,B,C1,C2} = applied vector.
    always_comb begin
        dut_a            = drive_q[3];
        dut_b            = drive_q[2];
        dut_c1           = drive_q[1];
        dut_c2           = drive_q[0];
        busy             = busy_q;
        done             = done_q;
        pass             = pass_q;
        err_count        = err_q;
        first_fail_vec   = ffv_q;
        first_fail_valid = ffvalid_q;
    end

endmodule

// File: tb/tb_oai211_sweep_ctrl.sv
// Directed bench for oai211_sweep_ctrl: cell models on dut_zn, latency, abort, reset.
`timescale 1ns/1ps
module tb_oai211_sweep_ctrl;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       abort;
    logic       dut_a, dut_b, dut_c1, dut_c2;
    logic       dut_zn;
    logic       busy, done, pass;
    logic [4:0] err_count;
    logic [3:0] first_fail_vec;
    logic       first_fail_valid;

    logic       start2;
    logic       a2, b2, c12, c22, zn2;
    logic       busy2, done2, pass2;
    logic [4:0] err2;
    logic [3:0] ffv2;
    logic       ffvalid2;

    int         zn_mode;
    int         n_tests;
    int         n_fail;
    int         lat;
    int         busy_cnt;
    int         err_at_start;
    int         valid_at_start;
    logic [3:0] vec_seen [16];
    logic [3:0] dv;

    oai211_sweep_ctrl #(.SETTLE_CYCLES(2)) u_dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .start            (start),
        .abort            (abort),
        .dut_a            (dut_a),
        .dut_b            (dut_b),
        .dut_c1           (dut_c1),
        .dut_c2           (dut_c2),
        .dut_zn           (dut_zn),
        .busy             (busy),
        .done             (done),
        .pass             (pass),
        .err_count        (err_count),
        .first_fail_vec   (first_fail_vec),
        .first_fail_valid (first_fail_valid)
    );

    oai211_sweep_ctrl #(.SETTLE_CYCLES(1)) u_dut1 (
        .clk              (clk),
        .rst_n            (rst_n),
        .start            (start2),
        .abort            (1'b0),
        .dut_a            (a2),
        .dut_b            (b2),
        .dut_c1           (c12),
        .dut_c2           (c22),
        .dut_zn           (zn2),
        .busy             (busy2),
        .done             (done2),
        .pass             (pass2),
        .err_count        (err2),
        .first_fail_vec   (ffv2),
        .first_fail_valid (ffvalid2)
    );

    always #5 clk = ~clk;

    assign dv = {dut_a, dut_b, dut_c1, dut_c2};

    // Cell models: 0 good, 1 stuck-at-0, 2 stuck-at-1, 3 non-inverting.
    always_comb begin
        case (zn_mode)
            0:       dut_zn = ~((dut_c1 | dut_c2) & dut_a & dut_b);
            1:       dut_zn = 1'b0;
            2:       dut_zn = 1'b1;
            default: dut_zn = (dut_c1 | dut_c2) & dut_a & dut_b;
        endcase
    end

    assign zn2 = ~((c12 | c22) & a2 & b2);

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One sweep on the SETTLE_CYCLES=2 instance; k counts edges after the start edge.
    task automatic run_sweep(input int mode, input int repulse_at, input int abort_at,
                             input int rst_at, input int max_k);
        zn_mode  = mode;
        lat      = 0;
        busy_cnt = 0;
        repeat (2) @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start          = 1'b0;
        err_at_start   = int'(err_count);
        valid_at_start = int'(first_fail_valid);
        for (int k = 1; k <= max_k; k++) begin
            @(negedge clk);
            start = (k == repulse_at);
            abort = (k == abort_at);
            if (busy) busy_cnt++;
            if ((k % 3 == 0) && (k / 3 >= 1) && (k / 3 <= 16)) vec_seen[k/3-1] = dv;
            if (k == rst_at) begin
                check("err_before_rst", int'(err_count), 9);
                check("vec_before_rst", int'(dv), 9);
                rst_n = 1'b0;
                #1;
                break;
            end
            @(posedge clk);
            #1;
            if (done) begin
                lat = k;
                break;
            end
        end
        start = 1'b0;
        abort = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got 1 expected 0");
        $fatal(1, "simulation did not finish");
    end

    initial begin
        int seen_done;
        int lat2;
        clk     = 1'b0;
        rst_n   = 1'b0;
        start   = 1'b0;
        start2  = 1'b0;
        abort   = 1'b0;
        zn_mode = 0;
        n_tests = 0;
        n_fail  = 0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy",  int'(busy), 0);
        check("rst_done",  int'(done), 0);
        check("rst_pass",  int'(pass), 0);
        check("rst_err",   int'(err_count), 0);
        check("rst_ffv",   int'(first_fail_vec), 0);
        check("rst_ffval", int'(first_fail_valid), 0);
        check("rst_dut",   int'(dv), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Good cell: 48-edge latency, clean pass, ascending vectors
        run_sweep(0, 0, 0, 0, 200);
        check("good_lat",   lat, 48);
        check("good_busy",  busy_cnt, 48);
        check("good_pass",  int'(pass), 1);
        check("good_err",   int'(err_count), 0);
        check("good_ffval", int'(first_fail_valid), 0);
        for (int n = 0; n < 16; n++) check($sformatf("good_vec%0d", n), int'(vec_seen[n]), n);
        check("good_busy_at_done", int'(busy), 0);
        @(posedge clk);
        #1;
        check("done_pulse", int'(done), 0);
        check("pass_hold",  int'(pass), 1);
        check("idle_dut",   int'(dv), 0);

        // Stuck-at-0
        run_sweep(1, 0, 0, 0, 200);
        check("sa0_lat",   lat, 48);
        check("sa0_err",   int'(err_count), 13);
        check("sa0_pass",  int'(pass), 0);
        check("sa0_ffv",   int'(first_fail_vec), 0);
        check("sa0_ffval", int'(first_fail_valid), 1);

        // Stuck-at-1
        run_sweep(2, 0, 0, 0, 200);
        check("sa1_err",   int'(err_count), 3);
        check("sa1_ffv",   int'(first_fail_vec), 13);
        check("sa1_pass",  int'(pass), 0);
        check("sa1_ffval", int'(first_fail_valid), 1);

        // Non-inverting cell, then a fresh start with the good cell
        run_sweep(3, 0, 0, 0, 200);
        check("inv_err",  int'(err_count), 16);
        check("inv_ffv",  int'(first_fail_vec), 0);
        check("inv_pass", int'(pass), 0);
        run_sweep(0, 0, 0, 0, 200);
        check("rerun_err_cleared",   err_at_start, 0);
        check("rerun_valid_cleared", valid_at_start, 0);
        check("rerun_pass", int'(pass), 1);
        check("rerun_err",  int'(err_count), 0);

        // start re-pulsed mid-sweep is ignored
        run_sweep(0, 20, 0, 0, 200);
        check("repulse_lat",  lat, 48);
        check("repulse_pass", int'(pass), 1);

        // abort during SAMPLE of vector 5 (stuck-at-0: vectors 0..4 counted)
        run_sweep(1, 0, 18, 0, 18);
        check("abort_busy",  int'(busy), 0);
        check("abort_dut",   int'(dv), 0);
        check("abort_done",  int'(done), 0);
        check("abort_pass",  int'(pass), 0);
        check("abort_err",   int'(err_count), 5);
        check("abort_ffval", int'(first_fail_valid), 1);
        check("abort_ffv",   int'(first_fail_vec), 0);
        seen_done = 0;
        for (int k = 0; k < 60; k++) begin
            @(posedge clk);
            #1;
            if (done || busy) seen_done = 1;
        end
        check("abort_no_done", seen_done, 0);

        // Async reset while vector 9 is applied
        run_sweep(1, 0, 0, 29, 200);
        check("arst_busy",  int'(busy), 0);
        check("arst_dut",   int'(dv), 0);
        check("arst_err",   int'(err_count), 0);
        check("arst_ffval", int'(first_fail_valid), 0);
        check("arst_pass",  int'(pass), 0);
        check("arst_done",  int'(done), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // SETTLE_CYCLES = 1 instance: 32-edge latency
        repeat (2) @(negedge clk);
        start2 = 1'b1;
        @(posedge clk);
        #1;
        start2 = 1'b0;
        lat2 = 0;
        for (int k = 1; k <= 100; k++) begin
            @(posedge clk);
            #1;
            if (done2) begin
                lat2 = k;
                break;
            end
        end
        check("s1_lat",  lat2, 32);
        check("s1_pass", int'(pass2), 1);
        check("s1_err",  int'(err2), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/oai211_sweep_ctrl.md
Name: oai211_sweep_ctrl

Overview:
Built-in self-test sequencer for one OAI211 cell instance, where ZN = ~((C1 | C2) & A & B). On start it drives all 16 input combinations in ascending order. After each vector settles, it samples ZN, compares it against the expected value, and counts mismatches. It sits between the test-control logic and the cell under test, and reports pass/fail, the error count and the first failing vector.

Parameters:
SETTLE_CYCLES, 2, clock cycles each vector is held before ZN is sampled; legal range 1..15.

Ports:
clk  input  1  clock, rising edge active
rst_n  input  1  asynchronous active-low reset
start  input  1  begin a sweep; sampled only in IDLE
abort  input  1  synchronous cancel of a running sweep
dut_a  output  1  drives cell input A
dut_b  output  1  drives cell input B
dut_c1  output  1  drives cell input C1
dut_c2  output  1  drives cell input C2
dut_zn  input  1  cell output ZN
busy  output  1  high while a sweep is running
done  output  1  one-cycle pulse when a sweep completes
pass  output  1  1 when the last completed sweep had zero mismatches
err_count  output  5  mismatch count of the current or last sweep, range 0..16
first_fail_vec  output  4  {A,B,C1,C2} of the first mismatching vector
first_fail_valid  output  1  first_fail_vec holds a captured vector

Behaviour:
- Reset is asynchronous on rst_n low.
  - State goes to IDLE.
  - All outputs go to 0: busy, done, pass, err_count, first_fail_vec, first_fail_valid, dut_a, dut_b, dut_c1, dut_c2.
  - Reset mid-sweep discards the sweep; no done pulse is issued.
- Vector register vec[3:0] maps to {dut_a, dut_b, dut_c1, dut_c2} = vec. The dut_* outputs are registered.
- Expected value: exp = ~((vec[1] | vec[0]) & vec[3] & vec[2]).
- States: IDLE, SETTLE, SAMPLE, DONE.
- IDLE:
  - dut_* = 0, busy = 0.
  - On start = 1: load vec = 0, err_count = 0, first_fail_valid = 0, pass = 0, settle counter = SETTLE_CYCLES - 1; go to SETTLE.
- SETTLE:
  - busy = 1.
  - Stay while the counter is nonzero, decrementing each cycle; go to SAMPLE when it reaches 0.
  - The state lasts exactly SETTLE_CYCLES cycles.
- SAMPLE (one cycle):
  - Compare dut_zn with exp.
  - On mismatch: err_count += 1. If first_fail_valid = 0, capture first_fail_vec = vec and set first_fail_valid = 1.
  - If vec = 15, go to DONE.
  - Otherwise vec += 1, reload the counter, go to SETTLE.
- DONE (one cycle):
  - done = 1, busy = 0, dut_* = 0.
  - pass = (err_count == 0), using the final count including vector 15.
  - Then go to IDLE.
- Result hold: pass, err_count, first_fail_vec and first_fail_valid hold their values until the next accepted start or reset.
- Latency: done is high in the cycle that starts 16 × (SETTLE_CYCLES + 1) rising edges after the edge that captured start. With the default of 2 that is 48 edges.
- Vector n is sampled at edge (n + 1) × (SETTLE_CYCLES + 1) after the start edge.
- start while busy, or in the DONE cycle, is ignored.
- abort:
  - In SETTLE or SAMPLE: on the next edge go to IDLE with dut_* = 0, pass = 0, no done pulse.
  - err_count and the first_fail fields keep their partial values; a SAMPLE compare in the abort cycle is not counted.
  - In IDLE or DONE, abort has no effect.
- abort and start asserted together in IDLE: start wins.
- err_count cannot overflow: at most 16 mismatches, in 5 bits.

Test Plan:
- Good cell model on dut_zn, SETTLE_CYCLES = 2, start pulse -> busy for 48 cycles; dut_* step through 0000..1111; done at edge 48; pass = 1; err_count = 0; first_fail_valid = 0.
- dut_zn stuck at 0 -> err_count = 13, pass = 0, first_fail_vec = 4'b0000, first_fail_valid = 1.
- dut_zn stuck at 1 -> err_count = 3 (vectors 1101, 1110, 1111), first_fail_vec = 4'b1101, pass = 0.
- dut_zn = non-inverted (C1 | C2) & A & B -> err_count = 16, first_fail_vec = 4'b0000. Then apply a second start with the good model -> err_count is cleared at start; final pass = 1.
- start re-pulsed mid-sweep is ignored (done still at edge 48). A separate run asserts abort while vec = 5 -> IDLE next edge, dut_* = 0, no done, pass = 0.
- rst_n low at vec = 9 -> all outputs 0 immediately. SETTLE_CYCLES = 1 run with the good model -> done at edge 32, pass = 1.
